// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencing controller for the 12-hour clock: holds the alarm setting,
// selects alarm vs time for the display, and sequences ringing/snooze/timeout.
module alarm_seq_ctrl #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MAX   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_min,
    input  logic [3:0] HOURS_TIME,
    input  logic [5:0] MINUTES_TIME,
    input  logic       AM_PM_TIME,
    input  logic       key_set,
    input  logic       key_hour,
    input  logic       key_min,
    input  logic       key_en,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       alarm,
    output logic [3:0] HOURS_OUT_alarm,
    output logic [5:0] MINUTES_OUT_alarm,
    output logic       AM_PM_OUT_alarm,
    output logic       alarm_on,
    output logic       BUZZ
);

    localparam logic [5:0] RING_LOAD   = 6'(RING_MAX);
    localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);

    typedef enum logic [1:0] {
        IDLE,
        SET_ALARM,
        RINGING,
        SNOOZE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic       am_pm_q, am_pm_d;
    logic       alarm_on_q, alarm_on_d;
    logic [5:0] ring_cnt_q, ring_cnt_d;
    logic [5:0] snooze_cnt_q, snooze_cnt_d;
    logic       match_q;
    logic       alarm_q;
    logic       buzz_q;
    logic       match;
    logic       trigger;

    assign match   = (HOURS_TIME == hours_q) && (MINUTES_TIME == minutes_q)
                     && (AM_PM_TIME == am_pm_q);
    // Rising edge of match only, so an alarm equal to the current time never re-fires.
    assign trigger = match && !match_q && alarm_on_q && (state_q == IDLE);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path infers a latch.
        state_d      = state_q;
        hours_d      = hours_q;
        minutes_d    = minutes_q;
        am_pm_d      = am_pm_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        alarm_on_d   = alarm_on_q ^ key_en;

        case (state_q)
            IDLE: begin
                if (key_set) begin
                    state_d = SET_ALARM;
                end else if (trigger) begin
                    state_d    = RINGING;
                    ring_cnt_d = RING_LOAD;
                end
            end
            SET_ALARM: begin
                if (key_set) begin
                    state_d = IDLE;
                end else begin
                    if (key_hour) begin
                        hours_d = (hours_q == 4'd12) ? 4'd1 : hours_q + 4'd1;
                        if (hours_q == 4'd11) am_pm_d = ~am_pm_q;
                    end
                    if (key_min) begin
                        minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                    end
                end
            end
            RINGING: begin
                if (key_stop) begin
                    state_d = IDLE;
                end else if (key_snooze) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = SNOOZE_LOAD;
                end else if (tick_min) begin
                    ring_cnt_d = ring_cnt_q - 6'd1;
                    if (ring_cnt_q <= 6'd1) state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (key_stop) begin
                    state_d = IDLE;
                end else if (tick_min) begin
                    snooze_cnt_d = snooze_cnt_q - 6'd1;
                    if (snooze_cnt_q <= 6'd1) begin
                        state_d    = RINGING;
                        ring_cnt_d = RING_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!alarm_on_d && (state_q == RINGING || state_q == SNOOZE)) state_d = IDLE;
    end

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hours_q      <= 4'd12;
            minutes_q    <= 6'd0;
            am_pm_q      <= 1'b0;
            alarm_on_q   <= 1'b0;
            ring_cnt_q   <= 6'd0;
            snooze_cnt_q <= 6'd0;
            match_q      <= 1'b0;
            alarm_q      <= 1'b0;
            buzz_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            am_pm_q      <= am_pm_d;
            alarm_on_q   <= alarm_on_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match;
            alarm_q      <= (state_d == SET_ALARM);
            buzz_q       <= (state_d == RINGING);
        end
    end

    assign alarm             = alarm_q;
    assign BUZZ              = buzz_q;
    assign alarm_on          = alarm_on_q;
    assign HOURS_OUT_alarm   = hours_q;
    assign MINUTES_OUT_alarm = minutes_q;
    assign AM_PM_OUT_alarm   = am_pm_q;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Directed self-checking bench for alarm_seq_ctrl: setting, wraps, trigger,
// snooze, timeout, key priorities and the non-retrigger rule.
module tb_alarm_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_min;
    logic [3:0] hours_time;
    logic [5:0] minutes_time;
    logic       am_pm_time;
    logic       key_set, key_hour, key_min, key_en, key_stop, key_snooze;
    logic       alarm;
    logic [3:0] hours_out;
    logic [5:0] minutes_out;
    logic       am_pm_out;
    logic       alarm_on;
    logic       buzz;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] K_SET    = 7'b000_0001;
    localparam logic [6:0] K_HOUR   = 7'b000_0010;
    localparam logic [6:0] K_MIN    = 7'b000_0100;
    localparam logic [6:0] K_EN     = 7'b000_1000;
    localparam logic [6:0] K_STOP   = 7'b001_0000;
    localparam logic [6:0] K_SNOOZE = 7'b010_0000;
    localparam logic [6:0] K_TICK   = 7'b100_0000;

    alarm_seq_ctrl #(.SNOOZE_MIN(5), .RING_MAX(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .tick_min         (tick_min),
        .HOURS_TIME       (hours_time),
        .MINUTES_TIME     (minutes_time),
        .AM_PM_TIME       (am_pm_time),
        .key_set          (key_set),
        .key_hour         (key_hour),
        .key_min          (key_min),
        .key_en           (key_en),
        .key_stop         (key_stop),
        .key_snooze       (key_snooze),
        .alarm            (alarm),
        .HOURS_OUT_alarm  (hours_out),
        .MINUTES_OUT_alarm(minutes_out),
        .AM_PM_OUT_alarm  (am_pm_out),
        .alarm_on         (alarm_on),
        .BUZZ             (buzz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present a one-cycle pulse on the selected inputs; returns at the negedge after it was sampled.
    task automatic press(input logic [6:0] k, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {tick_min, key_snooze, key_stop, key_en, key_min, key_hour, key_set} = k;
            @(negedge clk);
            {tick_min, key_snooze, key_stop, key_en, key_min, key_hour, key_set} = '0;
        end
    endtask

    task automatic set_time(input logic [3:0] h, input logic [5:0] m, input logic ap);
        @(negedge clk);
        hours_time   = h;
        minutes_time = m;
        am_pm_time   = ap;
        @(negedge clk);
    endtask

    task automatic check_setting(input string tag, input int h, input int m, input int ap);
        check({tag, "_hours"}, 32'(hours_out), 32'(h));
        check({tag, "_min"},   32'(minutes_out), 32'(m));
        check({tag, "_ampm"},  32'(am_pm_out), 32'(ap));
    endtask

    initial begin
        reset = 1'b1;
        {tick_min, key_snooze, key_stop, key_en, key_min, key_hour, key_set} = '0;
        hours_time   = 4'd3;
        minutes_time = 6'd0;
        am_pm_time   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_alarm", 32'(alarm), 0);
        check("rst_buzz", 32'(buzz), 0);
        check("rst_alarm_on", 32'(alarm_on), 0);
        check_setting("rst", 12, 0, 0);

        // Set 6:30 AM from 12:00 AM.
        press(K_SET);
        check("set_mode_alarm", 32'(alarm), 1);
        press(K_HOUR, 6);
        press(K_MIN, 30);
        check("set_mode_alarm_held", 32'(alarm), 1);
        check_setting("set_630", 6, 30, 0);
        press(K_SET);
        check("set_exit_alarm", 32'(alarm), 0);

        // Wraps: 6:30 AM -> 11:59 PM, then step across the boundaries.
        press(K_SET);
        press(K_HOUR, 17);
        press(K_MIN, 29);
        check_setting("wrap_1159pm", 11, 59, 1);
        press(K_HOUR);
        check_setting("wrap_1259am", 12, 59, 0);
        press(K_MIN);
        check_setting("wrap_1200am", 12, 0, 0);
        press(K_HOUR);
        check_setting("wrap_100am", 1, 0, 0);
        press(K_HOUR | K_MIN);
        check_setting("both_keys", 2, 1, 0);
        press(K_HOUR, 4);
        press(K_MIN, 29);
        press(K_SET | K_HOUR);
        check("exit_ignores_inc_alarm", 32'(alarm), 0);
        check_setting("exit_ignores_inc", 6, 30, 0);

        // Trigger, snooze, re-ring, timeout.
        press(K_EN);
        check("enable", 32'(alarm_on), 1);
        set_time(4'd6, 6'd29, 1'b0);
        check("pre_match_buzz", 32'(buzz), 0);
        set_time(4'd6, 6'd30, 1'b0);
        check("trigger_buzz", 32'(buzz), 1);
        press(K_SET | K_HOUR);
        check("ring_ignores_set_buzz", 32'(buzz), 1);
        check("ring_ignores_set_alarm", 32'(alarm), 0);
        check_setting("ring_ignores_hour", 6, 30, 0);
        press(K_SNOOZE);
        check("snooze_buzz", 32'(buzz), 0);
        press(K_TICK, 4);
        check("snooze_4_ticks", 32'(buzz), 0);
        press(K_TICK);
        check("snooze_done_buzz", 32'(buzz), 1);
        press(K_TICK);
        check("ring_1_tick", 32'(buzz), 1);
        press(K_TICK);
        check("ring_timeout", 32'(buzz), 0);
        repeat (3) @(negedge clk);
        check("no_retrigger_held_match", 32'(buzz), 0);

        // key_stop beats key_snooze: must land in IDLE, not SNOOZE.
        set_time(4'd6, 6'd31, 1'b0);
        set_time(4'd6, 6'd30, 1'b0);
        check("retrigger_buzz", 32'(buzz), 1);
        press(K_STOP | K_SNOOZE);
        check("stop_snooze_buzz", 32'(buzz), 0);
        press(K_TICK, 5);
        check("stop_went_idle", 32'(buzz), 0);

        // Disable while ringing.
        set_time(4'd6, 6'd31, 1'b0);
        set_time(4'd6, 6'd30, 1'b0);
        check("ring_again_buzz", 32'(buzz), 1);
        press(K_EN);
        check("disable_alarm_on", 32'(alarm_on), 0);
        check("disable_buzz", 32'(buzz), 0);
        press(K_TICK, 5);
        check("disable_stays_idle", 32'(buzz), 0);

        // Non-retrigger: alarm made equal to the running time inside SET_ALARM.
        press(K_EN);
        check("reenable", 32'(alarm_on), 1);
        set_time(4'd7, 6'd30, 1'b0);
        press(K_SET);
        press(K_HOUR);
        check_setting("equal_time", 7, 30, 0);
        check("equal_in_set_buzz", 32'(buzz), 0);
        press(K_SET);
        repeat (3) @(negedge clk);
        check("equal_exit_no_buzz", 32'(buzz), 0);
        set_time(4'd7, 6'd31, 1'b0);
        set_time(4'd7, 6'd30, 1'b0);
        check("equal_advance_back_buzz", 32'(buzz), 1);

        // Reset mid-RINGING drops BUZZ on the next edge.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_ring_buzz", 32'(buzz), 0);
        check("reset_ring_alarm_on", 32'(alarm_on), 0);
        check_setting("reset_ring", 12, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
